// File: rtl/exec_stage_mc.sv
// rtl/exec_stage_mc.sv - execute stage: forwarding, ALU, iterative multiplier, NZCV flags, EX/MEM register
module exec_stage_mc #(
  parameter int N  = 24,
  parameter int RB = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [N-1:0]  rd1,
  input  logic [N-1:0]  rd2,
  input  logic [N-1:0]  rd3,
  input  logic [N-1:0]  pc,
  input  logic [N-1:0]  imm,
  input  logic [N-1:0]  fwd_mem,
  input  logic [N-1:0]  fwd_wb,
  input  logic [1:0]    selA,
  input  logic [1:0]    selB,
  input  logic [1:0]    selC,
  input  logic [3:0]    aluControl,
  input  logic          setFlags,
  input  logic          branchFlag,
  input  logic          memWrite,
  input  logic          memToReg,
  input  logic          regWrite,
  input  logic [RB-1:0] Rc,
  output logic          stall_out,
  output logic          out_valid,
  output logic [N-1:0]  out_result,
  output logic [3:0]    out_flags,
  output logic [N-1:0]  out_store,
  output logic          out_branch,
  output logic          out_memWrite,
  output logic          out_memToReg,
  output logic          out_regWrite,
  output logic [RB-1:0] out_Rc
);
  localparam int SW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic [N-1:0]  op_a, op_b, op_c, alu_res, sra_v;
  logic [N:0]    wide;
  logic [SW-1:0] shamt;
  logic          alu_c, alu_v, shift_big, is_mul, take_mul;
  logic [3:0]    alu_flags, flag_q;

  // Multiplier working registers plus the control of the instruction it belongs to
  logic [N-1:0]  m_acc, m_cand, m_plier, m_store;
  logic [CW-1:0] m_cnt;
  logic          m_set, m_branch, m_mw, m_mr, m_rw;
  logic [RB-1:0] m_rc;

  // Operand forwarding select for the A, B and store-data paths
  always_comb begin
    case (selA)
      2'd0:    op_a = rd1;
      2'd1:    op_a = fwd_mem;
      2'd2:    op_a = fwd_wb;
      default: op_a = pc;
    endcase
    case (selB)
      2'd0:    op_b = rd2;
      2'd1:    op_b = fwd_mem;
      2'd2:    op_b = fwd_wb;
      default: op_b = imm;
    endcase
    case (selC)
      2'd0:    op_c = rd3;
      2'd1:    op_c = fwd_mem;
      2'd2:    op_c = fwd_wb;
      default: op_c = '0;
    endcase
  end

  assign shamt     = op_b[SW-1:0];
  assign shift_big = (int'(shamt) >= N);
  // Kept separate so the arithmetic shift is not turned unsigned by a surrounding mux
  assign sra_v     = $signed(op_a) >>> shamt;

  // Single-cycle ALU with carry/overflow for ADD and SUB only
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    wide    = '0;
    case (aluControl)
      4'd0: begin
        wide    = {1'b0, op_a} + {1'b0, op_b};
        alu_res = wide[N-1:0];
        alu_c   = wide[N];
        alu_v   = (op_a[N-1] == op_b[N-1]) && (alu_res[N-1] != op_a[N-1]);
      end
      4'd1: begin
        wide    = {1'b0, op_a} - {1'b0, op_b};
        alu_res = wide[N-1:0];
        alu_c   = ~wide[N];
        alu_v   = (op_a[N-1] != op_b[N-1]) && (alu_res[N-1] != op_a[N-1]);
      end
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      4'd5:    alu_res = shift_big ? '0 : op_a << shamt;
      4'd6:    alu_res = shift_big ? '0 : op_a >> shamt;
      4'd7:    alu_res = shift_big ? {N{op_a[N-1]}} : sra_v;
      4'd9:    alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  assign alu_flags = {alu_res[N-1], alu_res == '0, alu_c, alu_v};
  assign is_mul    = in_valid && (aluControl == OP_MUL);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // FSM next state; flush aborts any multiply, including one offered this cycle
  always_comb begin
    state_nx = state;
    take_mul = 1'b0;
    case (state)
      IDLE: if (is_mul) begin
        state_nx = BUSY;
        take_mul = 1'b1;
      end
      BUSY:    if (m_cnt == CW'(1)) state_nx = DONE;
      DONE:    if (en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx = IDLE;
      take_mul = 1'b0;
    end
  end

  assign stall_out = ~en | ((state == IDLE) & is_mul) | (state == BUSY) | ((state == DONE) & ~en);

  // Shift-add multiplier: one multiplier bit per BUSY cycle, counting N steps down
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_acc    <= '0;
      m_cand   <= '0;
      m_plier  <= '0;
      m_cnt    <= '0;
      m_store  <= '0;
      m_set    <= 1'b0;
      m_branch <= 1'b0;
      m_mw     <= 1'b0;
      m_mr     <= 1'b0;
      m_rw     <= 1'b0;
      m_rc     <= '0;
    end else if (take_mul) begin
      m_acc    <= '0;
      m_cand   <= op_a;
      m_plier  <= op_b;
      m_cnt    <= CW'(N);
      m_store  <= op_c;
      m_set    <= setFlags;
      m_branch <= branchFlag;
      m_mw     <= memWrite;
      m_mr     <= memToReg;
      m_rw     <= regWrite;
      m_rc     <= Rc;
    end else if (state == BUSY) begin
      if (m_plier[0]) m_acc <= m_acc + m_cand;
      m_cand  <= m_cand << 1;
      m_plier <= m_plier >> 1;
      m_cnt   <= m_cnt - CW'(1);
    end
  end

  // EX/MEM register and flag register; a multiply in flight hands MEM a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_store    <= '0;
      out_branch   <= 1'b0;
      out_memWrite <= 1'b0;
      out_memToReg <= 1'b0;
      out_regWrite <= 1'b0;
      out_Rc       <= '0;
      flag_q       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (en) begin
      if (state == DONE) begin
        out_valid    <= 1'b1;
        out_result   <= m_acc;
        out_store    <= m_store;
        out_branch   <= m_branch;
        out_memWrite <= m_mw;
        out_memToReg <= m_mr;
        out_regWrite <= m_rw;
        out_Rc       <= m_rc;
        if (m_set) flag_q <= {m_acc[N-1], m_acc == '0, 2'b00};
      end else if ((state == IDLE) && !is_mul) begin
        out_valid    <= in_valid;
        out_result   <= alu_res;
        out_store    <= op_c;
        out_branch   <= branchFlag;
        out_memWrite <= memWrite;
        out_memToReg <= memToReg;
        out_regWrite <= regWrite;
        out_Rc       <= Rc;
        if (in_valid && setFlags) flag_q <= alu_flags;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_flags = flag_q;
endmodule
